load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port. Turns CPU load/store requests into word-indexed mRD/mWR cycles on the word-wide data memory.
- Handles byte and halfword accesses: lane extraction plus sign/zero extension for loads, read-modify-write for sub-word stores.
- Sits between the MEM pipeline stage and DataMemory; stalls the CPU through busy/done.

Parameters:
- BIG_ENDIAN, 1, 1: byte offset 0 = bits[31:24]; 0: byte offset 0 = bits[7:0].
- MEM_WORDS, 258, number of words in the data memory; any word index >= MEM_WORDS is an error.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- uns  in  1  1 = zero-extend loads, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; right-justified for byte/half.
- rdata  out  32  extended load result; holds its value until the next done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned, illegal size, or out of range.
- busy  out  1  high whenever state != IDLE.
- mRD  out  1  memory read enable.
- mWR  out  1  memory write enable; memory captures on negedge CLK.
- DataAddr  out  32  word index = addr[31:2].
- DataIn  out  32  word written to memory.
- DataOut  in  32  memory read data; combinational, valid in the same cycle as mRD.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- All outputs are registered or decoded from the state register only (Moore). No combinational path from req to any memory-side output.
- States: IDLE, RD, WR, RESP.
- IDLE, req=1 at edge k: latch we, size, uns, addr, wdata. Then:
  - Error (size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS) -> RESP with err=1. No memory access.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD.
- RD (one cycle): mRD=1, DataAddr=addr[31:2]. Capture DataOut into the word buffer at the closing edge.
  - Load -> RESP.
  - Store -> WR.
- WR (one cycle): mWR=1; DataIn = wdata for word stores, otherwise the buffer with only the selected lane(s) replaced. -> RESP.
- RESP (one cycle): done=1; err as decided; rdata updated for successful loads only. -> IDLE.
- Latency from accept edge k: done high in cycle
  - k+1: error.
  - k+2: load or word store.
  - k+3: sub-word store.
- mRD and mWR are never both high. Each is high for exactly one cycle per access.
- Lane select uses addr[1:0] (byte) and addr[1] (half), mapped per BIG_ENDIAN.
- Load result: the byte/half is extended to 32 bits per uns. Word loads pass through; uns is ignored.
- req while busy, including the RESP cycle, is ignored; there is no queueing.
- Reset mid-operation: the next edge forces IDLE and clears mRD/mWR/done. No done is produced for the aborted access.
  - If RST is asserted during the WR cycle, mWR is already high in that cycle, so the negedge write still completes.
- DataAddr and DataIn hold their last values in IDLE.

Optional Feature:
- Macro: LSU_LED_MMIO_EN.
- Defined:
  - Adds output port led[3:0], reset 0.
  - In WR, if DataAddr == 128+i (i = 0..3), led[i] <= bit 0 of the merged word driven on DataIn.
  - Errored accesses never touch led.
- Undefined: no led port and no extra logic; memory traffic is identical in both builds.

Test Plan:
- Preload word 5 = 0x8899AABB, BIG_ENDIAN=1. lb addr 0x15, uns=0 -> mRD=1 for exactly one cycle with DataAddr=5; done at k+2; rdata=0xFFFFFF99; err=0.
- lhu addr 0x16 -> rdata=0x0000AABB, done at k+2. lw addr 0x14 -> rdata=0x8899AABB.
- sb addr 0x17, wdata=0x000000CC -> one RD cycle, then one WR cycle with DataIn=0x8899AACC. done at k+3. Word 5 reads back 0x8899AACC.
- sw addr 0x14, wdata=0x12345678 -> no mRD. mWR for one cycle, DataIn=0x12345678, done at k+2.
- Error accesses, each -> done with err=1 at k+1, mRD and mWR stay 0, rdata unchanged:
  - lh addr 0x13.
  - size=11.
  - lw addr 0x408 (word 258).
- Abort and ignore cases:
  - Pulse req again during RD -> ignored; exactly one done.
  - RST during RD -> IDLE next edge, mRD=0, no done.
  - (LSU_LED_MMIO_EN) sw addr 0x200, wdata=1 -> led=4'b0001.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: word-indexed data-memory initiator with sub-word loads/stores; `LSU_LED_MMIO_EN adds led[3:0] MMIO at words 128..131
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int MEM_WORDS  = 258
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mRD,
    output logic        mWR,
    output logic [31:0] DataAddr,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut
`ifdef LSU_LED_MMIO_EN
    ,
    output logic [3:0]  led
`endif
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t      state_q;
    logic        we_q, uns_q, done_q, err_q, busy_q, rd_q, wr_q;
    logic [1:0]  size_q, off_q;
    logic [15:0] wdata_q;
    logic [31:0] rdata_q, da_q, din_q;
    logic        bad_d;
    logic [4:0]  bsh_d, hsh_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d, merge_d;
`ifdef LSU_LED_MMIO_EN
    logic [3:0]  led_q;
    assign led = led_q;
`endif
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign mRD      = rd_q;
    assign mWR      = wr_q;
    assign DataAddr = da_q;
    assign DataIn   = din_q;
    // Request validity and lane extraction/insertion against the word on DataOut
    always_comb begin
        bad_d   = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)
                  || addr[31:2] >= 30'(MEM_WORDS);
        bsh_d   = {BIG_ENDIAN ? ~off_q : off_q, 3'b000};
        hsh_d   = {BIG_ENDIAN ? ~off_q[1] : off_q[1], 4'b0000};
        byte_d  = 8'(DataOut >> bsh_d);
        half_d  = 16'(DataOut >> hsh_d);
        load_d  = size_q == 2'b00 ? {{24{~uns_q & byte_d[7]}}, byte_d}
                : size_q == 2'b01 ? {{16{~uns_q & half_d[15]}}, half_d} : DataOut;
        merge_d = size_q == 2'b00 ? (DataOut & ~(32'h0000_00FF << bsh_d)) | ({24'h0, wdata_q[7:0]} << bsh_d)
                : (DataOut & ~(32'h0000_FFFF << hsh_d)) | ({16'h0, wdata_q} << hsh_d);
    end
    // Access sequencer; every port output is a register set on entry to its state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            wdata_q <= 16'h0;
            rdata_q <= 32'h0;
            da_q    <= 32'h0;
            din_q   <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef LSU_LED_MMIO_EN
            led_q   <= 4'h0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    we_q    <= we;
                    size_q  <= size;
                    uns_q   <= uns;
                    off_q   <= addr[1:0];
                    wdata_q <= wdata[15:0];
                    busy_q  <= 1'b1;
                    if (bad_d) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (!we || size != 2'b10) begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                        da_q    <= {2'b00, addr[31:2]};
                    end else begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                        da_q    <= {2'b00, addr[31:2]};
                        din_q   <= wdata;
                    end
                end
                RD: begin
                    rd_q <= 1'b0;
                    if (we_q) begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                        din_q   <= merge_d;
                    end else begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        rdata_q <= load_d;
                    end
                end
                WR: begin
                    wr_q    <= 1'b0;
                    state_q <= RESP;
                    done_q  <= 1'b1;
`ifdef LSU_LED_MMIO_EN
                    if (da_q[31:2] == 30'd32) led_q[da_q[1:0]] <= din_q[0];
`endif
                end
                RESP: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a negedge-write word memory
module tb_load_store_unit;
    logic        CLK, RST, req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, DataAddr, DataIn, DataOut;
    logic        done, err, busy, mRD, mWR;
`ifdef LSU_LED_MMIO_EN
    logic [3:0]  led;
`endif
    logic [31:0] mem [0:257];
    int          n_cmp, n_bad, lat, nrd, nwr, both, ndone;
    logic [31:0] rd_adr, din;
    logic        e;

    load_store_unit #(.BIG_ENDIAN(1'b1), .MEM_WORDS(258)) dut (
        .CLK(CLK), .RST(RST), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
        .busy(busy), .mRD(mRD), .mWR(mWR), .DataAddr(DataAddr), .DataIn(DataIn),
        .DataOut(DataOut)
`ifdef LSU_LED_MMIO_EN
        , .led(led)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign DataOut = DataAddr < 32'd258 ? mem[DataAddr[8:0]] : 32'h0;
    always @(negedge CLK) if (mWR && DataAddr < 32'd258) mem[DataAddr[8:0]] <= DataIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] wd);
        @(negedge CLK);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge CLK);
        #1 req = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; e = 1'bx;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (mRD) begin nrd++; rd_adr = DataAddr; end
            if (mWR) begin nwr++; din = DataIn; end
            if (mRD && mWR) both++;
            if (done) begin lat = c; e = err; end
            if (lat == 0) begin @(posedge CLK); #1; end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        req = 0; we = 0; size = 0; uns = 0; addr = 0; wdata = 0;
        for (int i = 0; i < 258; i++) mem[i] = 32'h0;
        mem[5]   = 32'h8899AABB;
        mem[257] = 32'hCAFEF00D;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_outs", {30'(0), done, err, busy, mRD, mWR}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", DataAddr, 32'h0);
        chk("rst_din", DataIn, 32'h0);
        RST = 1'b0;

        run(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
        chk("lb_lat", 32'(lat), 32'd2);
        chk("lb_nrd", 32'(nrd), 32'd1);
        chk("lb_nwr", 32'(nwr), 32'd0);
        chk("lb_adr", rd_adr, 32'd5);
        chk("lb_err", {31'b0, e}, 32'd0);
        chk("lb_rdata", rdata, 32'hFFFFFF99);

        run(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        chk("lhu_lat", 32'(lat), 32'd2);
        chk("lhu_rdata", rdata, 32'h0000AABB);

        run(1'b0, 2'b10, 1'b1, 32'h14, 32'h0);
        chk("lw_rdata", rdata, 32'h8899AABB);

        run(1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
        chk("lbu_rdata", rdata, 32'h00000088);

        run(1'b0, 2'b01, 1'b0, 32'h14, 32'h0);
        chk("lh_rdata", rdata, 32'hFFFF8899);

        run(1'b1, 2'b00, 1'b0, 32'h17, 32'h000000CC);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_nrd", 32'(nrd), 32'd1);
        chk("sb_nwr", 32'(nwr), 32'd1);
        chk("sb_both", 32'(both), 32'd0);
        chk("sb_din", din, 32'h8899AACC);
        chk("sb_mem", mem[5], 32'h8899AACC);
        chk("sb_rdata_hold", rdata, 32'hFFFF8899);

        run(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("sb_readback", rdata, 32'h8899AACC);

        run(1'b1, 2'b01, 1'b0, 32'h14, 32'h00001234);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_din", din, 32'h1234AACC);

        run(1'b1, 2'b10, 1'b0, 32'h14, 32'h12345678);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_nrd", 32'(nrd), 32'd0);
        chk("sw_nwr", 32'(nwr), 32'd1);
        chk("sw_din", din, 32'h12345678);
        chk("sw_mem", mem[5], 32'h12345678);

        run(1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
        chk("lw_last_err", {31'b0, e}, 32'd0);
        chk("lw_last_rdata", rdata, 32'hCAFEF00D);

        run(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        chk("lh_mis_lat", 32'(lat), 32'd1);
        chk("lh_mis_err", {31'b0, e}, 32'd1);
        chk("lh_mis_mem", 32'(nrd + nwr), 32'd0);
        chk("lh_mis_rdata", rdata, 32'hCAFEF00D);

        run(1'b0, 2'b11, 1'b0, 32'h14, 32'h0);
        chk("sz11_lat", 32'(lat), 32'd1);
        chk("sz11_err", {31'b0, e}, 32'd1);
        chk("sz11_mem", 32'(nrd + nwr), 32'd0);

        run(1'b0, 2'b10, 1'b0, 32'h408, 32'h0);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", {31'b0, e}, 32'd1);
        chk("oor_mem", 32'(nrd + nwr), 32'd0);
        chk("oor_rdata", rdata, 32'hCAFEF00D);

        run(1'b1, 2'b10, 1'b0, 32'h16, 32'hDEADBEEF);
        chk("sw_mis_err", {31'b0, e}, 32'd1);
        chk("sw_mis_mem", mem[5], 32'h12345678);

        @(negedge CLK);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h14;
        @(posedge CLK);
        #1 addr = 32'h404;
        chk("busy_rd", {31'b0, busy}, 32'd1);
        @(posedge CLK);
        #1 req = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            @(posedge CLK);
            #1;
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_rdata", rdata, 32'h12345678);

        @(negedge CLK);
        req = 1'b1; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h15;
        @(posedge CLK);
        #1 req = 1'b0;
        chk("abort_mrd_on", {31'b0, mRD}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_mrd_off", {31'b0, mRD}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        RST = 1'b0;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) ndone++;
            @(posedge CLK);
            #1;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);

`ifdef LSU_LED_MMIO_EN
        run(1'b1, 2'b10, 1'b0, 32'h200, 32'h1);
        chk("led", {28'b0, led}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
